// File: rtl/main_pkg.sv
// rtl/main_pkg.sv - shared types and constants for the main 8-bit CPU core
package main_pkg;

  typedef enum logic [3:0] {
    BOOT_LO, BOOT_HI, FETCH, OPER1, OPER2, EXEC, STK1, STK2, STK3
  } cpu_state_e;

  localparam logic [15:0] DEF_RESET_VECTOR = 16'hFFFC;
  localparam logic [15:0] DEF_IRQ_VECTOR   = 16'hFFFE;

  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_LDA_ZP  = 8'hA5;
  localparam logic [7:0] OP_STA_ZP  = 8'h85;
  localparam logic [7:0] OP_STX_ZP  = 8'h86;
  localparam logic [7:0] OP_STY_ZP  = 8'h84;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_TAY     = 8'hA8;
  localparam logic [7:0] OP_TYA     = 8'h98;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_CLI     = 8'h58;
  localparam logic [7:0] OP_SEI     = 8'h78;
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_JMP     = 8'h4C;
  localparam logic [7:0] OP_JSR     = 8'h20;
  localparam logic [7:0] OP_RTS     = 8'h60;
  localparam logic [7:0] OP_BRK     = 8'h00;
  localparam logic [7:0] OP_BEQ     = 8'hF0;
  localparam logic [7:0] OP_BNE     = 8'hD0;

  function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] v);
    logic [7:0] r;
    r      = p;
    r[P_N] = v[7];
    r[P_Z] = (v == 8'h00);
    return r;
  endfunction

  // Opcodes that leave FETCH through OPER1; everything else goes straight to EXEC.
  function automatic logic has_operand(input logic [7:0] op);
    logic r;
    case (op)
      OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_LDA_ZP, OP_STA_ZP, OP_STX_ZP,
      OP_STY_ZP, OP_STA_ABS, OP_JMP, OP_JSR, OP_RTS, OP_BRK, OP_BEQ, OP_BNE:
        r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/main_mem_if.sv
// rtl/main_mem_if.sv - 64 KiB byte memory with combinational read and clocked write
module mem_if (
  input  logic        clk,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        we,
  output logic [7:0]  rdata,
  output logic [7:0]  data_bus
);

  logic [7:0] memory [0:65535];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata    = memory[addr];
  assign data_bus = we ? wdata : rdata;

endmodule

// File: rtl/main.sv
// rtl/main.sv - small 6502-subset CPU core, one memory access per clock
module main
  import main_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [15:0] IRQ_VECTOR   = DEF_IRQ_VECTOR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rdy,
  output logic [15:0] address_bus,
  output logic [7:0]  data_bus,
  output logic        mem_read,
  output logic        mem_write,
  output logic [7:0]  dbg_A,
  output logic [7:0]  dbg_X,
  output logic [7:0]  dbg_Y,
  output logic [7:0]  dbg_P,
  output logic [15:0] dbg_PC
);

  cpu_state_e  state, state_n;
  logic [7:0]  a, x, y, sp, p, ir, op_lo, op_hi;
  logic [7:0]  a_n, x_n, y_n, sp_n, p_n, ir_n, op_lo_n, op_hi_n;
  logic [15:0] pc, pc_n;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic        rd, wr, taken;

  mem_if u_memif (
    .clk      (clk),
    .addr     (address_bus),
    .wdata    (wdata),
    .we       (mem_write),
    .rdata    (rdata),
    .data_bus (data_bus)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= BOOT_LO;
      a <= 8'h00; x <= 8'h00; y <= 8'h00; sp <= 8'hFD; p <= 8'h34;
      ir <= 8'h00; op_lo <= 8'h00; op_hi <= 8'h00; pc <= 16'h0000;
    end else if (rdy) begin
      state <= state_n;
      a <= a_n; x <= x_n; y <= y_n; sp <= sp_n; p <= p_n;
      ir <= ir_n; op_lo <= op_lo_n; op_hi <= op_hi_n; pc <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n = a; x_n = x; y_n = y; sp_n = sp; p_n = p;
    ir_n = ir; op_lo_n = op_lo; op_hi_n = op_hi; pc_n = pc;
    addr  = pc;
    wdata = 8'h00;
    rd    = 1'b0;
    wr    = 1'b0;
    taken = (ir == OP_BEQ) ? p[P_Z] : !p[P_Z];
    case (state)
      BOOT_LO: begin
        addr = RESET_VECTOR; rd = 1'b1; op_lo_n = rdata; state_n = BOOT_HI;
      end
      BOOT_HI: begin
        addr = RESET_VECTOR + 16'd1; rd = 1'b1; pc_n = {rdata, op_lo}; state_n = FETCH;
      end
      FETCH: begin
        rd = 1'b1; ir_n = rdata; pc_n = pc + 16'd1;
        state_n = has_operand(rdata) ? OPER1 : EXEC;
      end
      OPER1: begin
        state_n = EXEC;
        if (ir != OP_RTS) begin
          rd = 1'b1; op_lo_n = rdata; pc_n = pc + 16'd1;
          case (ir)
            OP_LDA_IMM: begin a_n = rdata; p_n = set_nz(p, rdata); state_n = FETCH; end
            OP_LDX_IMM: begin x_n = rdata; p_n = set_nz(p, rdata); state_n = FETCH; end
            OP_LDY_IMM: begin y_n = rdata; p_n = set_nz(p, rdata); state_n = FETCH; end
            OP_STA_ABS, OP_JMP: state_n = OPER2;
            OP_BRK:             state_n = STK1;
            OP_BEQ, OP_BNE:     state_n = taken ? EXEC : FETCH;
            default:            state_n = EXEC;
          endcase
        end
      end
      OPER2: begin
        rd = 1'b1; state_n = FETCH;
        case (ir)
          OP_STA_ABS: begin op_hi_n = rdata; pc_n = pc + 16'd1; state_n = EXEC; end
          OP_BRK:     begin addr = IRQ_VECTOR + 16'd1; pc_n = {rdata, op_lo}; end
          default:    pc_n = {rdata, op_lo};
        endcase
      end
      EXEC: begin
        state_n = FETCH;
        case (ir)
          OP_LDA_ZP:  begin addr = {8'h00, op_lo}; rd = 1'b1; a_n = rdata; p_n = set_nz(p, rdata); end
          OP_STA_ZP:  begin addr = {8'h00, op_lo}; wr = 1'b1; wdata = a; end
          OP_STX_ZP:  begin addr = {8'h00, op_lo}; wr = 1'b1; wdata = x; end
          OP_STY_ZP:  begin addr = {8'h00, op_lo}; wr = 1'b1; wdata = y; end
          OP_STA_ABS: begin addr = {op_hi, op_lo}; wr = 1'b1; wdata = a; end
          OP_JSR, OP_RTS: state_n = STK1;
          OP_BRK:     begin addr = IRQ_VECTOR; rd = 1'b1; op_lo_n = rdata; state_n = OPER2; end
          OP_BEQ, OP_BNE: pc_n = pc + {{8{op_lo[7]}}, op_lo};
          OP_TAX: begin x_n = a; p_n = set_nz(p, a); end
          OP_TXA: begin a_n = x; p_n = set_nz(p, x); end
          OP_TAY: begin y_n = a; p_n = set_nz(p, a); end
          OP_TYA: begin a_n = y; p_n = set_nz(p, y); end
          OP_INX: begin x_n = x + 8'h01; p_n = set_nz(p, x + 8'h01); end
          OP_INY: begin y_n = y + 8'h01; p_n = set_nz(p, y + 8'h01); end
          OP_DEX: begin x_n = x - 8'h01; p_n = set_nz(p, x - 8'h01); end
          OP_DEY: begin y_n = y - 8'h01; p_n = set_nz(p, y - 8'h01); end
          OP_CLC: p_n[P_C] = 1'b0;
          OP_SEC: p_n[P_C] = 1'b1;
          OP_CLI: p_n[P_I] = 1'b0;
          OP_SEI: p_n[P_I] = 1'b1;
          default: ;
        endcase
      end
      // RTS pulls through STK1/STK2; JSR and BRK push the return address there.
      STK1: begin
        state_n = STK2;
        if (ir == OP_RTS) begin
          addr = {8'h01, sp + 8'h01}; rd = 1'b1; sp_n = sp + 8'h01; op_lo_n = rdata;
        end else begin
          addr = {8'h01, sp}; wr = 1'b1; wdata = pc[15:8]; sp_n = sp - 8'h01;
        end
      end
      STK2: begin
        if (ir == OP_RTS) begin
          addr = {8'h01, sp + 8'h01}; rd = 1'b1; sp_n = sp + 8'h01; op_hi_n = rdata;
          state_n = STK3;
        end else begin
          addr = {8'h01, sp}; wr = 1'b1; wdata = pc[7:0]; sp_n = sp - 8'h01;
          state_n = (ir == OP_BRK) ? STK3 : OPER2;
        end
      end
      STK3: begin
        if (ir == OP_RTS) begin
          pc_n = {op_hi, op_lo} + 16'd1; state_n = FETCH;
        end else begin
          addr = {8'h01, sp}; wr = 1'b1; wdata = p | 8'h30; sp_n = sp - 8'h01;
          p_n[P_I] = 1'b1; state_n = EXEC;
        end
      end
      default: state_n = BOOT_LO;
    endcase
  end

  assign address_bus = addr;
  assign mem_read    = rd & rdy & reset_n;
  assign mem_write   = wr & rdy & reset_n;
  assign dbg_A       = a;
  assign dbg_X       = x;
  assign dbg_Y       = y;
  assign dbg_P       = (p | (8'h01 << P_U)) & ~(8'h01 << P_B);
  assign dbg_PC      = pc;

endmodule

// File: tb/tb_main.sv
// tb/tb_main.sv - directed self-checking bench for the main CPU core
module tb_main;

  logic        clk = 1'b0;
  logic        reset_n, rdy;
  logic [15:0] address_bus, dbg_PC;
  logic [7:0]  data_bus, dbg_A, dbg_X, dbg_Y, dbg_P;
  logic        mem_read, mem_write;

  int checks   = 0;
  int failures = 0;
  int writes;

  main dut (
    .clk(clk), .reset_n(reset_n), .rdy(rdy), .address_bus(address_bus),
    .data_bus(data_bus), .mem_read(mem_read), .mem_write(mem_write),
    .dbg_A(dbg_A), .dbg_X(dbg_X), .dbg_Y(dbg_Y), .dbg_P(dbg_P), .dbg_PC(dbg_PC)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    dut.u_memif.memory[a] = d;
  endtask

  task automatic do_reset(input logic [15:0] vec);
    reset_n = 1'b0;
    rdy     = 1'b1;
    tick(2);
    check("rst_A", dbg_A, 16'h00);
    check("rst_X", dbg_X, 16'h00);
    check("rst_Y", dbg_Y, 16'h00);
    check("rst_P", dbg_P, 16'h24);
    check("rst_PC", dbg_PC, 16'h0000);
    check("rst_rd", mem_read, 16'h0);
    check("rst_wr", mem_write, 16'h0);
    reset_n = 1'b1;
    #1;
    check("boot_lo_addr", address_bus, 16'hFFFC);
    check("boot_lo_rd", mem_read, 16'h1);
    tick(1);
    check("boot_hi_addr", address_bus, 16'hFFFD);
    check("boot_hi_rd", mem_read, 16'h1);
    tick(1);
    check("boot_pc", dbg_PC, vec);
    check("boot_fetch_rd", mem_read, 16'h1);
    check("boot_fetch_addr", address_bus, vec);
  endtask

  logic [7:0] prog_a [34] = '{
    8'hA9, 8'h42, 8'hA9, 8'h80, 8'hA9, 8'h00, 8'hA9, 8'h42, 8'h85, 8'h10,
    8'hA2, 8'h05, 8'hE8, 8'hCA, 8'hA0, 8'h00, 8'h88, 8'hC8, 8'hAA, 8'h38,
    8'h18, 8'hD0, 8'h02, 8'hA9, 8'hEE, 8'hF0, 8'h05, 8'h02, 8'h8D, 8'h00,
    8'h03, 8'h4C, 8'h00, 8'h20
  };

  initial begin
    reset_n = 1'b0;
    rdy     = 1'b1;
    for (int i = 0; i < 65536; i++) dut.u_memif.memory[i] = 8'hEA;
    poke(16'hFFFC, 8'h00);
    poke(16'hFFFD, 8'hFF);
    for (int i = 0; i < 34; i++) poke(16'hFF00 + 16'(i), prog_a[i]);
    poke(16'h2000, 8'h85);
    poke(16'h2001, 8'h20);

    do_reset(16'hFF00);
    tick(2); check("lda42_A", dbg_A, 16'h42); check("lda42_P", dbg_P, 16'h24);
    tick(2); check("lda80_A", dbg_A, 16'h80); check("lda80_P", dbg_P, 16'hA4);
    tick(2); check("lda00_A", dbg_A, 16'h00); check("lda00_P", dbg_P, 16'h26);
    tick(2); check("lda42b_A", dbg_A, 16'h42);

    writes = 0;
    for (int c = 0; c < 3; c++) begin
      if (mem_write) begin
        writes++;
        check("stazp_addr", address_bus, 16'h0010);
        check("stazp_data", data_bus, 16'h42);
      end
      tick(1);
    end
    check("stazp_writes", 16'(writes), 16'd1);
    check("stazp_mem", dut.u_memif.memory[16'h0010], 16'h42);

    tick(2); check("ldx_X", dbg_X, 16'h05);
    tick(2); check("inx_X", dbg_X, 16'h06);
    tick(2); check("dex_X", dbg_X, 16'h05);
    tick(2); check("ldy0_Y", dbg_Y, 16'h00); check("ldy0_P", dbg_P, 16'h26);
    tick(2); check("dey_wrap_Y", dbg_Y, 16'hFF); check("dey_P", dbg_P, 16'hA4);
    tick(2); check("iny_wrap_Y", dbg_Y, 16'h00); check("iny_P", dbg_P, 16'h26);
    tick(2); check("tax_X", dbg_X, 16'h42); check("tax_P", dbg_P, 16'h24);
    tick(2); check("sec_P", dbg_P, 16'h25);
    tick(2); check("clc_P", dbg_P, 16'h24);
    tick(3); check("bne_taken_PC", dbg_PC, 16'hFF19);
    tick(2); check("beq_not_PC", dbg_PC, 16'hFF1B);
    tick(2); check("undef_PC", dbg_PC, 16'hFF1C); check("undef_A", dbg_A, 16'h42);

    tick(2);
    rdy = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      check("stall_wr", mem_write, 16'h0);
      check("stall_rd", mem_read, 16'h0);
      check("stall_addr", address_bus, 16'hFF1E);
      tick(1);
    end
    check("stall_PC", dbg_PC, 16'hFF1E);
    check("stall_A", dbg_A, 16'h42);
    check("stall_nowrite", dut.u_memif.memory[16'h0300], 16'hEA);
    rdy = 1'b1;
    #1;
    writes = 0;
    for (int c = 0; c < 2; c++) begin
      if (mem_write) writes++;
      tick(1);
    end
    check("staabs_writes", 16'(writes), 16'd1);
    check("staabs_mem", dut.u_memif.memory[16'h0300], 16'h42);
    check("staabs_PC", dbg_PC, 16'hFF1F);
    tick(3); check("jmp_PC", dbg_PC, 16'h2000);

    tick(2);
    check("abort_pending_wr", mem_write, 16'h1);
    reset_n = 1'b0;
    tick(1);
    check("abort_mem", dut.u_memif.memory[16'h0020], 16'hEA);
    check("abort_wr", mem_write, 16'h0);
    check("abort_PC", dbg_PC, 16'h0000);

    poke(16'hFF00, 8'h20);
    poke(16'hFF01, 8'h34);
    poke(16'hFF02, 8'h12);
    poke(16'h1234, 8'h60);
    do_reset(16'hFF00);
    check("mem_kept", dut.u_memif.memory[16'h0010], 16'h42);
    tick(6);
    check("jsr_hi", dut.u_memif.memory[16'h01FD], 16'hFF);
    check("jsr_lo", dut.u_memif.memory[16'h01FC], 16'h02);
    check("jsr_SP", dut.sp, 16'hFB);
    check("jsr_PC", dbg_PC, 16'h1234);
    tick(6);
    check("rts_PC", dbg_PC, 16'hFF03);
    check("rts_SP", dut.sp, 16'hFD);

    poke(16'hFFFD, 8'h02);
    poke(16'hFFFE, 8'h00);
    poke(16'hFFFF, 8'h03);
    poke(16'h0200, 8'h00);
    poke(16'h0300, 8'h58);
    poke(16'h0301, 8'h78);
    do_reset(16'h0200);
    tick(7);
    check("brk_pch", dut.u_memif.memory[16'h01FD], 16'h02);
    check("brk_pcl", dut.u_memif.memory[16'h01FC], 16'h02);
    check("brk_p", dut.u_memif.memory[16'h01FB], 16'h34);
    check("brk_PC", dbg_PC, 16'h0300);
    check("brk_P", dbg_P, 16'h24);
    check("brk_SP", dut.sp, 16'hFA);
    tick(2); check("cli_P", dbg_P, 16'h20);
    tick(2); check("sei_P", dbg_P, 16'h24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
